// File: rtl/seq_det_param.sv
// Runtime-loadable LEN-bit serial pattern detector with overlap control and Mealy/Moore output.
// Optional saturating match counter and match_cnt port are compiled in with `define SEQ_DET_MATCH_CNT_EN.
module seq_det_param #(
  parameter int unsigned LEN   = 3,
  parameter int unsigned MEALY = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic             overlap,
  output logic             y,
`ifdef SEQ_DET_MATCH_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             armed
);

  localparam int unsigned HW = LEN - 1;
  localparam int unsigned FW = $clog2(LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);

  if (LEN < 2) begin : g_len_chk
    $error("seq_det_param: LEN must be at least 2");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("seq_det_param: CNT_W must be at least 1");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [LEN-1:0]  pat_q, pat_d;
  logic [HW-1:0]   hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            take;
  logic            hit;

  // Next-state: pattern load restarts everything, otherwise shift on qualified bits.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    take    = 1'b0;
    hit     = 1'b0;

    if (pat_load) begin
      state_d = RUN;
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
    end else if ((state_q == RUN) && x_valid && !rst) begin
      take   = 1'b1;
      hit    = (fill_q == FILL_MAX) && ({hist_q, x} == pat_q);
      // Low HW bits of {hist, x} drop the oldest bit; also covers LEN == 2.
      hist_d = HW'({hist_q, x});
      if (hit && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  assign armed = (state_q == RUN);

  if (MEALY != 0) begin : g_mealy
    assign y = hit;
  end else begin : g_moore
    logic y_q, y_d;

    // Registered detect pulse; a load clears it since no hit can coincide with a load.
    always_comb begin
      y_d = hit;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        y_q <= 1'b0;
      end else begin
        y_q <= y_d;
      end
    end

    assign y = y_q;
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating hit counter, cleared by a pattern load.
  always_comb begin
    cnt_d = cnt_q;
    if (pat_load) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

  logic unused_take;
  assign unused_take = take;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench: three detectors (LEN=3 Mealy, LEN=3 Moore, LEN=4 Mealy) share one directed stream.
// Expected values are queued per cycle by the driver and checked at the falling edge by a monitor.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [2:0] pat3 = 3'b000;
  logic [3:0] pat4 = 4'b1100;
  logic       overlap = 1'b1;

  logic y_m, y_o, y_4, armed_m, armed_o, armed_4;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [1:0] cnt_m_dut, cnt_o_dut, cnt_4_dut;
`endif

  always #5 clk = ~clk;

  seq_det_param #(.LEN(3), .MEALY(1), .CNT_W(2)) u_mealy (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat3), .overlap(overlap), .y(y_m),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt_m_dut),
`endif
    .armed(armed_m));

  seq_det_param #(.LEN(3), .MEALY(0), .CNT_W(2)) u_moore (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat3), .overlap(overlap), .y(y_o),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt_o_dut),
`endif
    .armed(armed_o));

  seq_det_param #(.LEN(4), .MEALY(1), .CNT_W(2)) u_len4 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat4), .overlap(overlap), .y(y_4),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt_4_dut),
`endif
    .armed(armed_4));

  typedef struct {
    int         id;
    logic       ym;
    logic       yo;
    logic       a;
    logic       y4;
    logic       c4;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec_n = 0;
  logic prev_hit = 1'b0;
  logic [1:0] cnt_model = 2'd0;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, want);
    end
  endtask

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input logic r, input logic l, input logic [2:0] p,
                      input logic xi, input logic xvi, input logic ovi,
                      input logic eym, input logic ea, input logic ey4, input logic c4);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pat_load = l; pat3 = p; x = xi; x_valid = xvi; overlap = ovi;
    e.id = vec_n; e.ym = eym; e.yo = prev_hit; e.a = ea;
    e.y4 = ey4; e.c4 = c4; e.cnt = cnt_model;
    exp_q.push_back(e);
    if (r || l) cnt_model = 2'd0;
    else if (eym && cnt_model != 2'd3) cnt_model = cnt_model + 2'd1;
    prev_hit = eym;
    vec_n++;
  endtask

  // Monitor: outputs are stable mid-cycle, after the driver has updated inputs.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("y_mealy", e.id, 8'(y_m), 8'(e.ym));
      chk("y_moore", e.id, 8'(y_o), 8'(e.yo));
      chk("armed_mealy", e.id, 8'(armed_m), 8'(e.a));
      chk("armed_moore", e.id, 8'(armed_o), 8'(e.a));
      if (e.c4) chk("y_len4", e.id, 8'(y_4), 8'(e.y4));
`ifdef SEQ_DET_MATCH_CNT_EN
      chk("cnt_mealy", e.id, 8'(cnt_m_dut), 8'(e.cnt));
      chk("cnt_moore", e.id, 8'(cnt_o_dut), 8'(e.cnt));
`endif
    end
  end

  localparam logic [2:0] P101 = 3'b101;
  localparam logic [2:0] P111 = 3'b111;

  initial begin
    // args: rst, load, pat, x, xv, ov | y_mealy, armed, y_len4, len4_checked
    step(1, 0, P101, 0, 0, 1,  0, 0, 0, 1);
    // Bits before any load are ignored
    step(0, 0, P101, 1, 1, 1,  0, 0, 0, 1);
    step(0, 0, P101, 0, 1, 1,  0, 0, 0, 1);
    step(0, 0, P101, 1, 1, 1,  0, 0, 0, 1);
    // Load 101, then 1 / gap / 0 / gap / 1
    step(0, 1, P101, 0, 0, 1,  0, 0, 0, 1);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  1, 1, 0, 0);
    // Overlapping: 0,1,1,1,0,1,0,1 hits on bits 6 and 8
    step(0, 1, P101, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  1, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  1, 1, 0, 0);
    // Non-overlapping 1,0,1,0,1: only bit 3
    step(0, 1, P101, 0, 0, 0,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 0,  0, 1, 0, 0);
    step(0, 0, P101, 0, 1, 0,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 0,  1, 1, 0, 0);
    step(0, 0, P101, 0, 1, 0,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 0,  0, 1, 0, 0);
    // Overlapping 1,0,1,0,1: bits 3 and 5
    step(0, 1, P101, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  1, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  1, 1, 0, 0);
    // Pattern 111 on 1,1,1,1: back-to-back hits
    step(0, 1, P111, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P111, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P111, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P111, 1, 1, 1,  1, 1, 0, 0);
    step(0, 0, P111, 1, 1, 1,  1, 1, 0, 0);
    // 1,0 then rst with a completing bit present, then 1 while IDLE
    step(0, 1, P101, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 0);
    step(1, 0, P101, 1, 1, 1,  0, 1, 0, 0);
    step(0, 0, P101, 1, 1, 1,  0, 0, 0, 1);
    // Reload with a bit in the load cycle (dropped); LEN4 1100 hits only at the final 0
    step(0, 1, P101, 1, 1, 1,  0, 0, 0, 1);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 1);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 1);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 1);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 1);
    step(0, 0, P101, 1, 1, 1,  0, 1, 0, 1);
    step(0, 0, P101, 0, 1, 1,  0, 1, 0, 1);
    step(0, 0, P101, 0, 1, 1,  0, 1, 1, 1);
    // Five overlapping hits: counter saturates at 3
    step(0, 1, P101, 0, 0, 1,  0, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(0, 0, P101, 1'((i + 1) % 2), 1, 1, 1'((i >= 2) && (i % 2 == 0)), 1, 0, 0);
    end
    step(0, 0, P101, 0, 0, 1,  0, 1, 0, 0);
    step(0, 0, P101, 0, 0, 1,  0, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial-bit pattern detector: the next generation of the fixed "101" Mealy/Moore detectors. It matches a runtime-loadable LEN-bit pattern on a qualified serial input, with selectable overlapping or non-overlapping detection and a compile-time Mealy/Moore output style. It sits on serial sampled-bit paths, for example after a UART/shift front end, and produces a one-cycle detect pulse plus an optional match counter.

## Interface
Parameters:
- LEN, 3: pattern length in bits; legal range LEN >= 2.
- MEALY, 1: output style. 1 = Mealy (combinational y); 0 = Moore (registered y).
- CNT_W, 8: match-counter width; used only when the counter is compiled in.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- x, in, 1: serial data bit.
- x_valid, in, 1: x is sampled only in cycles where this is 1.
- pat_load, in, 1: load pat_in and restart detection.
- pat_in, in, LEN: pattern. Bit LEN-1 is the first-received bit; bit 0 is the last.
- overlap, in, 1: 1 = overlapping detection; 0 = non-overlapping.
- y, out, 1: detect pulse.
- armed, out, 1: a pattern is loaded and the detector is in RUN.
- match_cnt, out, CNT_W: saturating count of matches. This port exists only with SEQ_DET_MATCH_CNT_EN.

## Operation
- **FSM states**
  - IDLE (entered on reset): x is ignored and y = 0.
  - RUN (entered from any state on pat_load).
  - There is no transition from RUN back to IDLE except via rst.
- **Registers**
  - pat_reg (LEN bits).
  - hist: shift history, LEN-1 bits.
  - fill: 0..LEN-1, the count of valid history bits; saturates at LEN-1.
  - y_q (Moore only).
  - match_cnt.
- **pat_load** (any state, highest priority after rst):
  - pat_reg <= pat_in.
  - hist <= 0 and fill <= 0.
  - match_cnt <= 0.
  - y_q <= 0.
  - State becomes RUN.
  - Any x_valid in the same cycle is dropped.
- **Sampling in RUN** with x_valid = 1 and no pat_load:
  - hist <= {hist[LEN-3:0], x}; for LEN = 2, hist <= x.
  - fill <= min(fill+1, LEN-1).
- **hit** = RUN and x_valid and no pat_load and fill == LEN-1 and {hist, x} == pat_reg.
- **On hit with overlap = 0:** fill <= 0, so the next match needs LEN fresh bits.
- **On hit with overlap = 1:** fill stays LEN-1, so a new match is possible on the very next valid bit.
- **overlap changes** take effect on the cycle they are seen; no state is flushed.
- **match_cnt** increments by 1 on each hit and saturates at 2^CNT_W-1 (no wrap).
- **armed** = (state == RUN).

## Timing
- **Reset values:**
  - y = 0, armed = 0, match_cnt = 0.
  - pat_reg = 0, hist = 0, fill = 0.
  - State = IDLE.
- **rst mid-stream:** rst wins over pat_load and x_valid. All state is cleared, including the pattern, and a pat_load is required before any further detection.
- **MEALY = 1:** y = hit, combinational from x and x_valid, in the same cycle as the completing bit.
- **MEALY = 0:** y_q <= hit, so y is high for exactly one cycle, the cycle after the completing bit.
- **Moore with back-to-back overlapping hits:** y stays high for consecutive cycles.
- **match_cnt** updates on the edge that ends the hit cycle. It is visible one cycle after the completing bit, for both output styles.
- **Gaps:** x_valid = 0 cycles neither shift the history nor reset it. Patterns may span gaps of any length.
- **Throughput:** one bit per cycle, with no stall.

## Configuration
- Macro: SEQ_DET_MATCH_CNT_EN.
- **Defined:** the CNT_W-bit saturating match counter and the match_cnt port are present, with the behaviour above.
- **Undefined:** there is no counter register and no match_cnt port. CNT_W is ignored, and all other behaviour is identical.

## Test plan
1. **Overlapping Mealy detection.** LEN=3, MEALY=1, load pattern 3'b101, overlap=1, one bit per cycle on stream 0,1,1,1,0,1,0,1 -> y=1 in the cycles of bit 6 and bit 8 only. match_cnt=2.
2. **Non-overlap vs overlap.** Same pattern, stream 1,0,1,0,1.
   - overlap=0 -> y only on bit 3; match_cnt=1.
   - Repeated with overlap=1 -> y on bits 3 and 5; match_cnt=2.
3. **Moore latency.** MEALY=0, same stimulus as scenario 1 -> y high in the cycle after bits 6 and 8, one cycle each, and no combinational path from x to y.
4. **Gaps and IDLE.** Before any pat_load, drive 1,0,1 -> y=0 and armed=0. Then load 101 and drive 1, three idle cycles, 0, one idle cycle, 1 -> exactly one hit, on the final valid bit.
5. **Reset and reload.** Drive 1,0, then assert rst, then 1 -> no hit and armed=0. Then load 4'b1100 with LEN=4 while driving x_valid=1 in the load cycle -> that bit is dropped, and stream 1,1,0,0 hits on the fourth bit.
6. **Counter saturation.** CNT_W=2 with the macro defined, overlap=1, pattern 101, stream 1,0,1,0,1,0,1,0,1,0,1 (5 hits) -> match_cnt saturates at 3, and y still pulses on all 5 hits.
